aer_transmitter: RTL and testbench

AER_TRANSMITTER -- requirements
Module: aer_transmitter

---
 rtl/aer_pkg.sv | 15 +
 rtl/sync_ff.sv | 24 ++
 rtl/aer_transmitter.sv | 124 ++++++++++++
 tb/tb_aer_transmitter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared types and constants for the AER transmitter.
package aer_pkg;

    // Default width of the bundled AER address, matching the event FIFO word.
    localparam int AER_ADDR_WIDTH = 16;

    // Transmitter handshake states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/aer_transmitter.sv
// AER transmitter: pops events from a show-ahead FIFO and sends each
// address over a 4-phase req/ack handshake, with an optional ack timeout.
module aer_transmitter
    import aer_pkg::*;
#(
    parameter int DATA_WIDTH  = AER_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] aer_addr,
    output logic                  aer_req,
    input  logic                  aer_ack,
    output logic                  busy,
    output logic [15:0]           sent_cnt,
    output logic                  timeout_err
);

    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value on the edge before it reaches TIMEOUT; the edge that
    // takes it to TIMEOUT is the one that drops req.
    localparam logic [TCNT_W-1:0] TCNT_LAST = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    tx_state_t         state;
    tx_state_t         state_next;
    logic              ack_s;
    logic [TCNT_W-1:0] tcnt;
    logic              dropped;
    logic              fetch;
    logic              tmo_hit;
    logic              done;
    logic [15:0]       sent_cnt_next;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (aer_ack),
        .q       (ack_s)
    );

    // Next-state logic plus fetch, timeout and completion strobes.
    always_comb begin
        state_next    = state;
        fetch         = reset_n && (state == IDLE) && en && !fifo_empty;
        tmo_hit       = TIMEOUT_EN && (state == REQ_HI) && !ack_s && (tcnt == TCNT_LAST);
        done          = (state == REQ_LO) && !ack_s;
        sent_cnt_next = (done && !dropped) ? sent_cnt + 16'd1 : sent_cnt;
        case (state)
            IDLE:    if (fetch) state_next = SETUP;
            SETUP:   state_next = REQ_HI;
            REQ_HI:  if (ack_s || tmo_hit) state_next = REQ_LO;
            REQ_LO:  if (!ack_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fifo_rd = fetch;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered request: high exactly while the FSM sits in REQ_HI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aer_req <= 1'b0;
        end else begin
            aer_req <= (state_next == REQ_HI);
        end
    end

    // Latch the event address on the pop edge and hold it until the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aer_addr <= '0;
        end else if (fetch) begin
            aer_addr <= fifo_data;
        end
    end

    // Ack-wait counter, cleared on entry to REQ_HI, plus drop/error tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt        <= '0;
            dropped     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == SETUP) begin
                tcnt    <= '0;
                dropped <= 1'b0;
            end else if (state == REQ_HI) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tmo_hit) begin
                dropped     <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end

    // Completed-handshake counter, wrapping modulo 2^16.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_cnt <= '0;
        end else begin
            sent_cnt <= sent_cnt_next;
        end
    end

endmodule

// File: tb/tb_aer_transmitter.sv
// Directed testbench for aer_transmitter with a FIFO and receiver model.
module tb_aer_transmitter;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd;
    logic [15:0] aer_addr;
    logic        aer_req;
    logic        aer_ack;
    logic        busy;
    logic [15:0] sent_cnt;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    // FIFO model
    logic [15:0] mem [0:31];
    logic [4:0]  wr_ptr = '0;
    logic [4:0]  rd_ptr = '0;
    int          rd_count = 0;

    // Receiver model
    logic ack_reg   = 1'b0;
    logic ack_zero  = 1'b0;
    logic ack_never = 1'b0;
    int   ack_dly   = 1;
    int   ack_cnt   = 0;

    // Monitor
    int          cyc = 0;
    logic        req_prev = 1'b0;
    logic [15:0] addr_prev = '0;
    logic [15:0] rise_addr [0:31];
    int          rise_cyc [0:31];
    int          n_rise = 0;
    int          fall_cyc = 0;
    int          addr_err = 0;

    aer_transmitter #(
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .aer_addr    (aer_addr),
        .aer_req     (aer_req),
        .aer_ack     (aer_ack),
        .busy        (busy),
        .sent_cnt    (sent_cnt),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr];
    assign aer_ack    = ack_zero ? aer_req : ack_reg;

    // FIFO pop on the DUT strobe.
    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_ptr   <= rd_ptr + 5'd1;
            rd_count <= rd_count + 1;
        end
    end

    // Receiver: ack follows req after ack_dly cycles; optionally never rises.
    always @(posedge clk) begin
        if ((aer_req !== ack_reg) && !(ack_never && aer_req)) begin
            if (ack_cnt + 1 >= ack_dly) begin
                ack_reg <= aer_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    // Log req rises/falls and check the address was stable the cycle before.
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        req_prev  <= aer_req;
        addr_prev <= aer_addr;
        if (aer_req && !req_prev) begin
            rise_addr[n_rise[4:0]] <= aer_addr;
            rise_cyc[n_rise[4:0]]  <= cyc;
            n_rise                 <= n_rise + 1;
            if (aer_addr !== addr_prev) addr_err <= addr_err + 1;
        end
        if (!aer_req && req_prev) fall_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 5'd1;
    endtask

    // Wait (bounded) until the link is quiet; optionally also require an empty FIFO.
    task automatic wait_quiet(input string tag, input bit need_empty);
        int n = 0;
        while (!(busy === 1'b0 && aer_req === 1'b0 && aer_ack === 1'b0 &&
                 (!need_empty || fifo_empty)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < 300) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req_high(input string tag);
        int n = 0;
        while (aer_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, aer_req}, 32'd1);
    endtask

    initial begin
        int base;
        int rd0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset: outputs at reset values, no pop while reset_n=0.
        reset_n = 1'b0;
        en      = 1'b1;
        push(16'h0012);
        repeat (2) @(negedge clk);
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_req", {31'd0, aer_req}, 32'd0);
        chk("rst_addr", {16'd0, aer_addr}, 32'd0);
        chk("rst_cnt", {16'd0, sent_cnt}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("en0_no_rd", rd_count, 32'd0);

        // Single event, ack after 3 cycles.
        ack_dly = 3;
        base    = n_rise;
        en      = 1'b1;
        #1;
        chk("t1_fifo_rd", {31'd0, fifo_rd}, 32'd1);
        wait_quiet("t1_done", 1'b1);
        chk("t1_rd_pulses", rd_count, 32'd1);
        chk("t1_rises", n_rise - base, 32'd1);
        chk("t1_addr", {16'd0, rise_addr[base]}, 32'h0012);
        chk("t1_addr_setup", addr_err, 32'd0);
        chk("t1_cnt", {16'd0, sent_cnt}, 32'd1);

        // Three back-to-back events, zero-delay ack: 8-cycle period, no bubble.
        ack_zero = 1'b1;
        ack_dly  = 1;
        base     = n_rise;
        rd0      = rd_count;
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        @(negedge clk);
        wait_quiet("t2_done", 1'b1);
        chk("t2_rd_pulses", rd_count - rd0, 32'd3);
        chk("t2_addr0", {16'd0, rise_addr[base]}, 32'h0001);
        chk("t2_addr1", {16'd0, rise_addr[base+1]}, 32'h0002);
        chk("t2_addr2", {16'd0, rise_addr[base+2]}, 32'h0003);
        chk("t2_period01", rise_cyc[base+1] - rise_cyc[base], 32'd8);
        chk("t2_period12", rise_cyc[base+2] - rise_cyc[base+1], 32'd8);
        chk("t2_cnt", {16'd0, sent_cnt}, 32'd4);
        chk("t2_addr_setup", addr_err, 32'd0);
        ack_zero = 1'b0;

        // Ack never rises: req drops after 8 cycles, event dropped.
        ack_never = 1'b1;
        base      = n_rise;
        push(16'h00A5);
        @(negedge clk);
        wait_quiet("t3_done", 1'b1);
        chk("t3_req_width", fall_cyc - rise_cyc[base], 32'd8);
        chk("t3_terr", {31'd0, timeout_err}, 32'd1);
        chk("t3_cnt", {16'd0, sent_cnt}, 32'd4);
        ack_never = 1'b0;
        base      = n_rise;
        push(16'h00B6);
        @(negedge clk);
        wait_quiet("t3b_done", 1'b1);
        chk("t3b_addr", {16'd0, rise_addr[base]}, 32'h00B6);
        chk("t3b_cnt", {16'd0, sent_cnt}, 32'd5);
        chk("t3b_terr_sticky", {31'd0, timeout_err}, 32'd1);

        // en dropped during REQ_HI with two events queued.
        ack_dly = 4;
        base    = n_rise;
        rd0     = rd_count;
        push(16'h0C01);
        push(16'h0C02);
        wait_req_high("t4_req_up");
        en = 1'b0;
        wait_quiet("t4_done", 1'b0);
        repeat (5) @(negedge clk);
        chk("t4_rd_pulses", rd_count - rd0, 32'd1);
        chk("t4_cnt", {16'd0, sent_cnt}, 32'd6);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("t4_addr", {16'd0, rise_addr[base]}, 32'h0C01);
        en = 1'b1;
        @(negedge clk);
        wait_quiet("t4b_done", 1'b1);
        chk("t4b_rd_pulses", rd_count - rd0, 32'd2);
        chk("t4b_addr", {16'd0, rise_addr[base+1]}, 32'h0C02);
        chk("t4b_cnt", {16'd0, sent_cnt}, 32'd7);

        // Reset pulsed during REQ_HI: req drops immediately, entry not re-read.
        ack_dly = 5;
        rd0     = rd_count;
        push(16'h0D0D);
        wait_req_high("t5_req_up");
        reset_n = 1'b0;
        #1;
        chk("t5_req_async", {31'd0, aer_req}, 32'd0);
        chk("t5_addr", {16'd0, aer_addr}, 32'd0);
        chk("t5_cnt", {16'd0, sent_cnt}, 32'd0);
        chk("t5_terr", {31'd0, timeout_err}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_reread", rd_count - rd0, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Counter wrap: preload near the top, then two handshakes.
        ack_dly = 1;
        force dut.sent_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.sent_cnt;
        @(negedge clk);
        chk("t6_preload", {16'd0, sent_cnt}, 32'hFFFE);
        push(16'h0E01);
        push(16'h0E02);
        @(negedge clk);
        wait_quiet("t6_done", 1'b1);
        chk("t6_wrap", {16'd0, sent_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
